// File: rtl/afu_issue.sv
// Two-stage issue/capture front end for the ALU functional unit (S1 drives the AFU, S2 holds the result).
// Define AFU_ISSUE_PERF_EN to add the perf_issued / perf_stall counters.
module afu_issue #(
   parameter int RSZ    = 32,
   parameter int PC_SZ  = 32,
   parameter int TAG_SZ = 5,
   parameter int SEL_SZ = 2,
   parameter int OP_SZ  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [RSZ-1:0]    req_rs1,
   input  logic [RSZ-1:0]    req_rs2,
   input  logic [RSZ-1:0]    req_imm,
   input  logic [PC_SZ-1:0]  req_pc,
   input  logic [SEL_SZ-1:0] req_sel_x,
   input  logic [SEL_SZ-1:0] req_sel_y,
   input  logic [OP_SZ-1:0]  req_op,
   input  logic [TAG_SZ-1:0] req_rd,
   output logic [RSZ-1:0]    afu_rs1_data,
   output logic [RSZ-1:0]    afu_rs2_data,
   output logic [PC_SZ-1:0]  afu_pc,
   output logic [RSZ-1:0]    afu_imm,
   output logic [SEL_SZ-1:0] afu_sel_x,
   output logic [SEL_SZ-1:0] afu_sel_y,
   output logic [OP_SZ-1:0]  afu_op,
   input  logic [RSZ-1:0]    afu_rd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [RSZ-1:0]    rsp_data,
   output logic [TAG_SZ-1:0] rsp_rd
`ifdef AFU_ISSUE_PERF_EN
   ,
   output logic [31:0]       perf_issued,
   output logic [31:0]       perf_stall
`endif
);

   logic              s1_valid;
   logic              s2_valid;
   logic [TAG_SZ-1:0] s1_rd;
   logic              s1_adv;
   logic              s2_adv;
   logic              accept;

   assign s2_adv    = !s2_valid || rsp_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign req_ready = s1_adv && !flush;
   assign accept    = req_valid && req_ready;
   assign rsp_valid = s2_valid;

   // S1 data only loads on accept, so the AFU inputs stay quiet when idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid     <= 1'b0;
         afu_rs1_data <= '0;
         afu_rs2_data <= '0;
         afu_pc       <= '0;
         afu_imm      <= '0;
         afu_sel_x    <= '0;
         afu_sel_y    <= '0;
         afu_op       <= '0;
         s1_rd        <= '0;
      end else begin
         // NOTE: flush only clears the valid; accept is already blocked by req_ready.
         if (flush)       s1_valid <= 1'b0;
         else if (s1_adv) s1_valid <= accept;
         if (accept) begin
            afu_rs1_data <= req_rs1;
            afu_rs2_data <= req_rs2;
            afu_pc       <= req_pc;
            afu_imm      <= req_imm;
            afu_sel_x    <= req_sel_x;
            afu_sel_y    <= req_sel_y;
            afu_op       <= req_op;
            s1_rd        <= req_rd;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_valid <= 1'b0;
         rsp_data <= '0;
         rsp_rd   <= '0;
      end else if (flush) begin
         s2_valid <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            rsp_data <= afu_rd_data;
            rsp_rd   <= s1_rd;
         end
      end
   end

`ifdef AFU_ISSUE_PERF_EN
   // Free-running counters; flush does not touch them and they wrap naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_issued <= '0;
         perf_stall  <= '0;
      end else begin
         if (accept)                  perf_issued <= perf_issued + 32'd1;
         if (req_valid && !req_ready) perf_stall  <= perf_stall + 32'd1;
      end
   end
`endif

endmodule
